sprite_blitter: RTL and testbench
=================================

Name: sprite_blitter

Overview:
- Single-sprite copy engine: ROM image -> vga_adapter plot port.
- Sits downstream of the draw sequencer FSM, which supplies origin, size and ROM base with a start pulse.
- Sits upstream of vga_adapter (320x240, 12-bit colour); it drives x/y/colour/plot directly.
- Replaces ad-hoc gated-clock drawing with a single-clock, latency-aware, clipped, transparency-keyed raster walk.

Parameters:
SCREEN_W, 320, screen width in pixels; pixels with x >= SCREEN_W are clipped
SCREEN_H, 240, screen height; pixels with y >= SCREEN_H are clipped
ROM_AW, 16, ROM address width
COLOUR_W, 12, colour width (4 bits per channel)
ROM_LATENCY, 1, clock edges from rom_address register update to valid rom_q (range 1..3)
TRANSP_EN, 1, 1 = pixels equal to TRANSP_KEY are not plotted
TRANSP_KEY, 12'hF0F, transparent colour value

Ports:
CLOCK_50  in  1  system clock; all logic is on its rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  request pulse; sampled only in IDLE
x_origin  in  9  screen x of sprite column 0
y_origin  in  8  screen y of sprite row 0
width  in  9  sprite width in pixels (0 allowed)
height  in  8  sprite height in pixels (0 allowed)
base_addr  in  ROM_AW  ROM address of pixel (0,0); the image is row-major, with row stride = width
busy  out  1  high from the start-accept edge until the done edge
done  out  1  one-cycle pulse when the last pixel has been emitted
rom_address  out  ROM_AW  registered ROM address
rom_q  in  COLOUR_W  ROM data
x  out  9  plot x (registered)
y  out  8  plot y (registered)
colour  out  COLOUR_W  plot colour (registered)
plot  out  1  write strobe to vga_adapter (registered)

Behaviour:
- Reset values (asserted asynchronously): state IDLE; busy, done, plot = 0; x, y, colour, rom_address = 0; delay line fully invalid.
- Reset mid-operation: plot drops immediately and no done pulse is generated. A start after reset release is accepted normally.
- States: IDLE, FETCH, DRAIN, FINISH.
- IDLE:
  - On start=1 at edge T0: latch all inputs, set busy=1, set rom_address=base_addr, set col=row=0.
  - If width==0 or height==0, go to FINISH; otherwise go to FETCH.
- FETCH:
  - Each edge issues one address; rom_address increments by 1 per pixel (linear, wraps modulo 2^ROM_AW).
  - col increments; when col==width-1, col returns to 0 and row increments.
  - After the address for (width-1, height-1) is issued, go to DRAIN.
  - For N = width*height, the last address is issued at edge T0+N-1.
- Delay line: ROM_LATENCY stages carrying {valid, x_abs, y_abs}, aligned with rom_q.
  - x_abs = x_origin + col, computed 10 bits wide.
  - y_abs = y_origin + row, computed 9 bits wide. No wrap-around onto the screen.
- Output register, loaded every edge:
  - plot <= valid AND x_abs < SCREEN_W AND y_abs < SCREEN_H AND NOT (TRANSP_EN AND rom_q == TRANSP_KEY).
  - x, y are the low 9 and 8 bits; colour = rom_q.
  - x, y and colour may change while plot=0 (don't-care).
- Pixel k (0-based, raster order) is presented at edge T0+k+ROM_LATENCY+1.
- DRAIN: wait until the delay line is empty, then go to FINISH.
- FINISH:
  - Register done=1 and busy=0, then return to IDLE.
  - For the normal path, done is at edge T0+N+ROM_LATENCY+1.
  - For zero-size, done is at edge T0+1 and plot is never asserted.
- start while busy: ignored; no queueing. start in the same cycle as done: ignored (not in IDLE).
- Latched inputs decouple the engine; changes to x_origin/base_addr etc. while busy have no effect.
- Throughput: 1 pixel/clock, with no gaps within a sprite.

Decomposition:
- Package vga_draw_pkg:
  - SCREEN_W, SCREEN_H, COLOUR_W, ROM_AW, TRANSP_KEY default.
  - Blitter state enum {IDLE, FETCH, DRAIN, FINISH}.
  - Shared by the draw sequencer and the top level.
- Sub-module pixel_delay_line: parameterised ROM_LATENCY-deep shift register of {valid, x_abs[9:0], y_abs[8:0]}, with async active-high clear.

Test Plan:
- 4x2 sprite at (10,20), base 0x0010, ROM[a]=a, ROM_LATENCY=1, TRANSP_EN=0 -> 8 consecutive plots at edges T0+2..T0+9:
  - (10,20)..(13,20) with colours 0x010..0x013;
  - (10,21)..(13,21) with colours 0x014..0x017;
  - done pulse at T0+10; busy high T0..T0+9.
- Transparency: same sprite, ROM[0x012]=0xF0F, TRANSP_EN=1 -> plot low only at (12,20); 7 plots; done timing unchanged.
- Clipping: 4x2 at (318,239) -> plots only at (318,239) and (319,239); no plot with x>=320 or y>=240; done at T0+10.
- Zero-size: width=0, height=5 -> done at T0+1, plot never high, rom_address=base.
- Busy rejection: second start pulse during FETCH of a 16x16 sprite -> ignored; exactly 256 plots; a single done.
- Reset mid-op: assert reset at pixel 5 of a 16x16 sprite -> plot/busy low asynchronously, no done. A new 2x2 start after release completes in 2*2+1+1 cycles.

Source files
------------

// File: rtl/vga_draw_pkg.sv
// -----------------------------------------------------------------------------
// vga_draw_pkg
// Shared definitions for the VGA drawing path: the draw sequencer and the
// sprite blitter.
//   - Default screen geometry, colour width, ROM address width and the
//     transparent colour key.
//   - Blitter state encoding.
//   - Pixel tag carried alongside the ROM read: {valid, x_abs, y_abs}.
// -----------------------------------------------------------------------------
package vga_draw_pkg;

    localparam int DEF_SCREEN_W = 320;
    localparam int DEF_SCREEN_H = 240;
    localparam int DEF_COLOUR_W = 12;
    localparam int DEF_ROM_AW   = 16;

    localparam logic [11:0] DEF_TRANSP_KEY = 12'hF0F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } blit_state_e;

    // Absolute coordinates are one bit wider than the screen coordinates so
    // that a sprite running off the right/bottom edge is clipped rather than
    // wrapped back onto the screen.
    typedef struct packed {
        logic       valid;
        logic [9:0] x_abs;
        logic [8:0] y_abs;
    } pix_tag_t;

endpackage

// File: rtl/pixel_delay_line.sv
// -----------------------------------------------------------------------------
// pixel_delay_line
// DEPTH-stage shift register of pixel tags, used to keep the screen position
// of each pixel aligned with the ROM data that arrives DEPTH edges after its
// address was issued.
// Ports:
//   clk      - clock, rising edge
//   clear    - asynchronous active-high clear (all stages invalid)
//   tag_in   - tag of the pixel whose address is being issued this cycle
//   tag_out  - tag aligned with the current ROM data
//   pending  - a valid tag exists in a stage other than the last one
// -----------------------------------------------------------------------------
module pixel_delay_line
    import vga_draw_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic     clk,
    input  logic     clear,
    input  pix_tag_t tag_in,
    output pix_tag_t tag_out,
    output logic     pending
);

    pix_tag_t stage_r [DEPTH];
    logic     pending_s;

    // Shift the tags one stage per clock; clear invalidates every stage.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    // Anything still in flight ahead of the last stage keeps the engine busy.
    always_comb begin
        pending_s = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            pending_s = pending_s | stage_r[i].valid;
        end
    end

    assign tag_out = stage_r[DEPTH-1];
    assign pending = pending_s;

endmodule

// File: rtl/sprite_blitter.sv
// -----------------------------------------------------------------------------
// sprite_blitter
// Copies one row-major sprite image from ROM to the vga_adapter plot port,
// one pixel per clock, clipping to the screen and skipping the transparent
// colour key.
// Ports:
//   CLOCK_50     - system clock (rising edge)
//   reset        - asynchronous active-high reset
//   start        - request pulse, honoured only while idle
//   x_origin     - screen x of sprite column 0
//   y_origin     - screen y of sprite row 0
//   width        - sprite width in pixels (0 allowed)
//   height       - sprite height in pixels (0 allowed)
//   base_addr    - ROM address of pixel (0,0); row stride equals width
//   busy         - high from the accepting edge until the done edge
//   done         - one-cycle pulse after the last pixel has been emitted
//   rom_address  - registered ROM address
//   rom_q        - ROM data, valid ROM_LATENCY edges after rom_address
//   x, y, colour - registered plot coordinates and colour
//   plot         - registered write strobe
// -----------------------------------------------------------------------------
module sprite_blitter
    import vga_draw_pkg::*;
#(
    parameter int                  SCREEN_W    = DEF_SCREEN_W,
    parameter int                  SCREEN_H    = DEF_SCREEN_H,
    parameter int                  ROM_AW      = DEF_ROM_AW,
    parameter int                  COLOUR_W    = DEF_COLOUR_W,
    parameter int                  ROM_LATENCY = 1,
    parameter bit                  TRANSP_EN   = 1'b1,
    parameter logic [COLOUR_W-1:0] TRANSP_KEY  = DEF_TRANSP_KEY
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                start,
    input  logic [8:0]          x_origin,
    input  logic [7:0]          y_origin,
    input  logic [8:0]          width,
    input  logic [7:0]          height,
    input  logic [ROM_AW-1:0]   base_addr,
    output logic                busy,
    output logic                done,
    output logic [ROM_AW-1:0]   rom_address,
    input  logic [COLOUR_W-1:0] rom_q,
    output logic [8:0]          x,
    output logic [7:0]          y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot
);

    blit_state_e state_r;
    blit_state_e next_state_s;

    // Request parameters latched on acceptance so the caller may change
    // its inputs while the sprite is being drawn.
    logic [8:0] x_org_r;
    logic [7:0] y_org_r;
    logic [8:0] width_r;
    logic [7:0] height_r;

    // Raster position of the pixel whose address is currently on rom_address.
    logic [8:0] col_r;
    logic [7:0] row_r;

    logic     zero_size_s;
    logic     last_s;
    logic     accept_s;
    logic     advance_s;
    logic     busy_d_s;
    logic     done_d_s;
    logic     dl_pending_s;
    logic     visible_s;
    logic     key_hit_s;
    pix_tag_t fetch_tag_s;
    pix_tag_t data_tag_s;

    assign zero_size_s = (width == 9'd0) || (height == 8'd0);
    assign last_s      = (col_r == (width_r - 9'd1)) && (row_r == (height_r - 8'd1));

    // Tag of the pixel being issued; valid only while walking the image.
    assign fetch_tag_s.valid = (state_r == FETCH);
    assign fetch_tag_s.x_abs = {1'b0, x_org_r} + {1'b0, col_r};
    assign fetch_tag_s.y_abs = {1'b0, y_org_r} + {1'b0, row_r};

    pixel_delay_line #(
        .DEPTH   (ROM_LATENCY)
    ) u_delay (
        .clk     (CLOCK_50),
        .clear   (reset),
        .tag_in  (fetch_tag_s),
        .tag_out (data_tag_s),
        .pending (dl_pending_s)
    );

    // FSM state register.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = zero_size_s ? FINISH : FETCH;
                end else begin
                    next_state_s = IDLE;
                end
            end
            FETCH: begin
                if (last_s) begin
                    next_state_s = DRAIN;
                end else begin
                    next_state_s = FETCH;
                end
            end
            DRAIN: begin
                // The last stage empties into the output register on the
                // same edge, so only earlier stages need to be clear.
                if (!dl_pending_s) begin
                    next_state_s = FINISH;
                end else begin
                    next_state_s = DRAIN;
                end
            end
            FINISH: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // FSM output decode; busy/done are the next values of their registers.
    always_comb begin
        accept_s  = 1'b0;
        advance_s = 1'b0;
        busy_d_s  = 1'b0;
        done_d_s  = 1'b0;
        case (state_r)
            IDLE: begin
                accept_s = start;
                busy_d_s = start;
            end
            FETCH: begin
                advance_s = ~last_s;
                busy_d_s  = 1'b1;
            end
            DRAIN: begin
                busy_d_s = 1'b1;
            end
            FINISH: begin
                done_d_s = 1'b1;
            end
            default: begin
                busy_d_s = 1'b0;
            end
        endcase
    end

    // Request latch, address generator and raster counters.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            x_org_r     <= 9'd0;
            y_org_r     <= 8'd0;
            width_r     <= 9'd0;
            height_r    <= 8'd0;
            col_r       <= 9'd0;
            row_r       <= 8'd0;
            rom_address <= '0;
        end else begin
            busy <= busy_d_s;
            done <= done_d_s;
            if (accept_s) begin
                x_org_r     <= x_origin;
                y_org_r     <= y_origin;
                width_r     <= width;
                height_r    <= height;
                col_r       <= 9'd0;
                row_r       <= 8'd0;
                rom_address <= base_addr;
            end else if (advance_s) begin
                // Linear address walk; wraps naturally at 2^ROM_AW.
                rom_address <= rom_address + ROM_AW'(1);
                if (col_r == (width_r - 9'd1)) begin
                    col_r <= 9'd0;
                    row_r <= row_r + 8'd1;
                end else begin
                    col_r <= col_r + 9'd1;
                end
            end else begin
                col_r <= col_r;
            end
        end
    end

    assign visible_s = (data_tag_s.x_abs < 10'(SCREEN_W)) && (data_tag_s.y_abs < 9'(SCREEN_H));
    assign key_hit_s = TRANSP_EN && (rom_q == TRANSP_KEY);

    // Plot output register, reloaded every edge from the aligned tag and ROM data.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            plot   <= 1'b0;
            x      <= 9'd0;
            y      <= 8'd0;
            colour <= '0;
        end else begin
            plot   <= data_tag_s.valid && visible_s && !key_hit_s;
            x      <= data_tag_s.x_abs[8:0];
            y      <= data_tag_s.y_abs[7:0];
            colour <= rom_q;
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// -----------------------------------------------------------------------------
// tb_sprite_blitter
// Directed bench for sprite_blitter with a one-cycle-latency ROM whose
// contents are ROM[a] = a[11:0], optionally with ROM[0x0012] = 0xF0F.
// -----------------------------------------------------------------------------
module tb_sprite_blitter;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        start;
    logic [8:0]  x_origin;
    logic [7:0]  y_origin;
    logic [8:0]  width;
    logic [7:0]  height;
    logic [15:0] base_addr;
    logic        busy;
    logic        done;
    logic [15:0] rom_address;
    logic [11:0] rom_q = 12'h000;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [11:0] colour;
    logic        plot;

    int checks   = 0;
    int failures = 0;
    int plot_count;
    int done_count;
    bit key_on   = 1'b0;

    sprite_blitter dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .start       (start),
        .x_origin    (x_origin),
        .y_origin    (y_origin),
        .width       (width),
        .height      (height),
        .base_addr   (base_addr),
        .busy        (busy),
        .done        (done),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .plot        (plot)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [11:0] rom_fn(input logic [15:0] a);
        if (key_on && (a == 16'h0012)) begin
            return 12'hF0F;
        end
        return a[11:0];
    endfunction

    // Synchronous ROM: one edge from address to data.
    always @(posedge CLOCK_50) begin
        rom_q <= rom_fn(rom_address);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Start a sprite and check every edge against the expected raster.
    // sec: relative edge at which a second start pulse is driven (0 = none).
    task automatic run_sprite(input logic [8:0] xo, input logic [7:0] yo,
                              input logic [8:0] w, input logic [7:0] h,
                              input logic [15:0] base, input int sec,
                              input int exp_plots);
        int   n;
        int   done_at;
        int   k;
        int   xa;
        int   ya;
        logic ep;
        n       = int'(w) * int'(h);
        done_at = (n == 0) ? 1 : n + 2;
        x_origin  = xo;
        y_origin  = yo;
        width     = w;
        height    = h;
        base_addr = base;
        start     = 1'b1;
        tick();
        chk("busy_at_t0", busy, 1);
        chk("addr_at_t0", rom_address, base);
        plot_count = 0;
        done_count = 0;
        for (int r = 1; r <= done_at + 3; r++) begin
            start = (r == sec);
            if (r == sec) begin
                x_origin  = xo + 9'd50;
                base_addr = base + 16'h0100;
            end
            tick();
            k  = r - 2;
            ep = 1'b0;
            xa = 0;
            ya = 0;
            if (k >= 0 && k < n) begin
                xa = int'(xo) + (k % int'(w));
                ya = int'(yo) + (k / int'(w));
                ep = (xa < 320) && (ya < 240) &&
                     !(key_on && ((base + 16'(k)) == 16'h0012));
            end
            chk("plot", plot, ep);
            if (ep) begin
                chk("x", x, xa[8:0]);
                chk("y", y, ya[7:0]);
                chk("colour", colour, rom_fn(base + 16'(k)));
            end
            chk("busy", busy, (r < done_at));
            chk("done", done, (r == done_at));
            if (plot === 1'b1) plot_count++;
            if (done === 1'b1) done_count++;
        end
        start = 1'b0;
        chk("plot_count", plot_count, exp_plots);
        chk("done_count", done_count, 1);
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        x_origin  = 9'd0;
        y_origin  = 8'd0;
        width     = 9'd0;
        height    = 8'd0;
        base_addr = 16'h0000;
        #1 reset = 1'b1;
        #1;
        chk("rst_plot", plot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", rom_address, 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_colour", colour, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // 4x2 sprite at (10,20), no key colour present.
        key_on = 1'b0;
        run_sprite(9'd10, 8'd20, 9'd4, 8'd2, 16'h0010, 0, 8);

        // Same sprite with ROM[0x012] = key: (12,20) skipped.
        key_on = 1'b1;
        run_sprite(9'd10, 8'd20, 9'd4, 8'd2, 16'h0010, 0, 7);
        key_on = 1'b0;

        // Clipping at bottom-right corner.
        run_sprite(9'd318, 8'd239, 9'd4, 8'd2, 16'h0030, 0, 2);

        // Zero width; start held into the done edge is ignored.
        run_sprite(9'd7, 8'd7, 9'd0, 8'd5, 16'h0ABC, 1, 0);

        // 16x16 with a second start (and changed inputs) during FETCH.
        run_sprite(9'd0, 8'd0, 9'd16, 8'd16, 16'h0100, 5, 256);

        // Reset in the middle of a 16x16 sprite.
        x_origin  = 9'd100;
        y_origin  = 8'd50;
        width     = 9'd16;
        height    = 8'd16;
        base_addr = 16'h0200;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 1; r <= 6; r++) begin
            tick();
        end
        chk("pre_reset_plot", plot, 1);
        chk("pre_reset_x", x, 9'd104);
        #2 reset = 1'b1;
        #1;
        chk("async_plot", plot, 0);
        chk("async_busy", busy, 0);
        chk("async_addr", rom_address, 0);
        tick();
        chk("rst_hold_done", done, 0);
        tick();
        reset = 1'b0;
        for (int r = 1; r <= 3; r++) begin
            tick();
            chk("post_rst_done", done, 0);
            chk("post_rst_busy", busy, 0);
            chk("post_rst_plot", plot, 0);
        end

        // Fresh 2x2 after reset: done at T0+6.
        run_sprite(9'd5, 8'd6, 9'd2, 8'd2, 16'h0040, 0, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
